// File: rtl/servo_pkg.sv
// Shared constants and parser state type for the servo frame scheduler.
// Imported by the top level and the per-axis slew limiter.
package servo_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hFF;
  localparam logic [7:0] CENTER_POS = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    GET_X,
    GET_Y,
    GET_CS
  } parser_state_t;

endpackage

// File: rtl/servo_slew_limiter.sv
// One servo axis: holds the position output and walks it toward the target
// by at most SLEW_MAX LSBs each time i_step_en is high.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int SLEW_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_step_en,
  input  logic [7:0] i_target,
  output logic [7:0] o_pos
);

  localparam logic signed [8:0] SLEW_S = 9'(SLEW_MAX);
  localparam logic [7:0]        STEP   = 8'(SLEW_MAX);

  logic [7:0]        r_pos;
  logic signed [8:0] w_diff;
  logic [7:0]        w_pos_next;

  // Both operands are zero-extended, so the 9-bit difference never overflows.
  always_comb begin
    w_diff     = $signed({1'b0, i_target}) - $signed({1'b0, r_pos});
    w_pos_next = i_target;
    if (w_diff > SLEW_S) begin
      w_pos_next = r_pos + STEP;
    end else if (w_diff < -SLEW_S) begin
      w_pos_next = r_pos - STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= CENTER_POS;
    end else if (i_step_en) begin
      r_pos <= w_pos_next;
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/servo_frame_scheduler.sv
// Parses SYNC/X/Y/CSUM packets from the UART byte stream and commits servo
// targets at frame boundaries, falling back to centre when the link goes quiet.
module servo_frame_scheduler
  import servo_pkg::*;
#(
  parameter int FRAME_TICKS    = 2502,
  parameter int SLEW_MAX       = 4,
  parameter int TIMEOUT_FRAMES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pos_x,
  output logic [7:0] pos_y,
  output logic       frame_strobe,
  output logic       link_ok,
  output logic [7:0] err_count
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_FRAMES);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_FRAMES - 1);

  parser_state_t    r_state, w_state_next;
  logic [7:0]       r_x, r_y;
  logic [7:0]       r_target_x, r_target_y;
  logic [7:0]       r_err_count;
  logic             r_link_ok;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_next;
  logic             r_frame_strobe;
  logic [TO_W-1:0]  r_timeout_cnt;
  logic             r_commit_seen;
  logic             w_commit, w_csum_err, w_frame_had_commit, w_expire;

  // A SYNC byte restarts the packet from any state, so it never counts as an error.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_csum_err   = 1'b0;
    if (rx_valid) begin
      if (rx_data == SYNC_BYTE) begin
        w_state_next = GET_X;
      end else begin
        case (r_state)
          GET_X:   w_state_next = GET_Y;
          GET_Y:   w_state_next = GET_CS;
          GET_CS: begin
            w_state_next = IDLE;
            if (rx_data == (r_x ^ r_y)) w_commit = 1'b1;
            else                        w_csum_err = 1'b1;
          end
          default: w_state_next = r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_next;
      if (rx_valid && rx_data != SYNC_BYTE) begin
        if (r_state == GET_X) r_x <= rx_data;
        if (r_state == GET_Y) r_y <= rx_data;
      end
    end
  end

  // The strobe is registered one cycle early so it lines up with the last count.
  assign w_frame_cnt_next = (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt    <= '0;
      r_frame_strobe <= 1'b0;
    end else begin
      r_frame_cnt    <= w_frame_cnt_next;
      r_frame_strobe <= (w_frame_cnt_next == FRAME_LAST);
    end
  end

  assign w_frame_had_commit = w_commit || r_commit_seen;
  assign w_expire = r_frame_strobe && !w_frame_had_commit && (r_timeout_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_cnt <= '0;
      r_commit_seen <= 1'b0;
    end else if (r_frame_strobe) begin
      r_commit_seen <= 1'b0;
      if (w_frame_had_commit)          r_timeout_cnt <= '0;
      else if (r_timeout_cnt != TO_MAX) r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end else if (w_commit) begin
      r_commit_seen <= 1'b1;
      r_timeout_cnt <= '0;
    end
  end

  // A commit outranks a timeout expiring in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target_x  <= CENTER_POS;
      r_target_y  <= CENTER_POS;
      r_link_ok   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_commit) begin
        r_target_x <= r_x;
        r_target_y <= r_y;
        r_link_ok  <= 1'b1;
      end else if (w_expire) begin
        r_target_x <= CENTER_POS;
        r_target_y <= CENTER_POS;
        r_link_ok  <= 1'b0;
      end
      if (w_csum_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  servo_slew_limiter #(.SLEW_MAX(SLEW_MAX)) u_slew_x (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_step_en (r_frame_strobe),
    .i_target  (r_target_x),
    .o_pos     (pos_x)
  );

  servo_slew_limiter #(.SLEW_MAX(SLEW_MAX)) u_slew_y (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_step_en (r_frame_strobe),
    .i_target  (r_target_y),
    .o_pos     (pos_y)
  );

  assign frame_strobe = r_frame_strobe;
  assign link_ok      = r_link_ok;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Self-checking bench for servo_frame_scheduler: packet vectors, hand-written
// corner sequences and random traffic against a behavioural packet model.
module tb_servo_frame_scheduler;

  localparam int FT = 16;
  localparam int SM = 4;
  localparam int TO = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pos_x, pos_y, err_count;
  logic       frame_strobe, link_ok;

  int checks = 0;
  int errors = 0;

  servo_frame_scheduler #(
    .FRAME_TICKS    (FT),
    .SLEW_MAX       (SM),
    .TIMEOUT_FRAMES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .frame_strobe (frame_strobe),
    .link_ok      (link_ok),
    .err_count    (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: cycles since reset, bytes gathered since the last SYNC,
  // and whole frames elapsed without a good packet.
  int         mCycle, mPosX, mPosY, mTgtX, mTgtY, mErr, mFrames;
  bit         mLink, mSynced, mSeen;
  logic [7:0] mBuf[$];

  function automatic int slewToward(input int p, input int t);
    if (t - p > SM) return p + SM;
    if (p - t > SM) return p - SM;
    return t;
  endfunction

  task automatic modelReset();
    mCycle = 0; mPosX = 128; mPosY = 128; mTgtX = 128; mTgtY = 128;
    mErr = 0; mFrames = 0; mLink = 0; mSynced = 0; mSeen = 0;
    mBuf.delete();
  endtask

  task automatic modelStep(input logic v, input logic [7:0] d);
    bit commit;
    bit strobeNow;
    int cx, cy;
    commit = 0; cx = 0; cy = 0;
    strobeNow = (mCycle % FT == FT - 1);
    if (v) begin
      if (d == 8'hFF) begin
        mSynced = 1;
        mBuf.delete();
      end else if (mSynced) begin
        mBuf.push_back(d);
        if (mBuf.size() == 3) begin
          if ((mBuf[0] ^ mBuf[1]) == mBuf[2]) begin
            commit = 1; cx = int'(mBuf[0]); cy = int'(mBuf[1]);
          end else if (mErr < 255) begin
            mErr++;
          end
          mSynced = 0;
          mBuf.delete();
        end
      end
    end
    if (strobeNow) begin
      mPosX = slewToward(mPosX, mTgtX);
      mPosY = slewToward(mPosY, mTgtY);
      if (commit || mSeen) begin
        mFrames = 0;
      end else if (mFrames < TO) begin
        mFrames++;
        if (mFrames == TO) begin
          mLink = 0; mTgtX = 128; mTgtY = 128;
        end
      end
      mSeen = 0;
    end else if (commit) begin
      mSeen = 1;
      mFrames = 0;
    end
    if (commit) begin
      mTgtX = cx; mTgtY = cy; mLink = 1;
    end
    mCycle++;
  endtask

  task automatic checkOutput(input string name);
    bit expStrobe;
    expStrobe = (mCycle % FT == FT - 1) && rst_n;
    checks++;
    if (pos_x !== 8'(mPosX) || pos_y !== 8'(mPosY) || frame_strobe !== expStrobe ||
        link_ok !== mLink || err_count !== 8'(mErr)) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got x=%0d y=%0d stb=%0b link=%0b err=%0d, expected x=%0d y=%0d stb=%0b link=%0b err=%0d",
               name, $time, pos_x, pos_y, frame_strobe, link_ok, err_count,
               mPosX, mPosY, expStrobe, mLink, mErr);
    end
  endtask

  task automatic expectEq(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    modelStep(v, d);
    @(posedge clk);
    #1;
    checkOutput("cycle");
  endtask

  task automatic sendPacket(input logic [7:0] x, input logic [7:0] y, input logic [7:0] cs);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, x);
    applyStimulus(1'b1, y);
    applyStimulus(1'b1, cs);
  endtask

  task automatic sendRand(input logic [7:0] d);
    applyStimulus(1'b1, d);
    repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic resetDut();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    modelReset();
    #1;
    checkOutput("reset immediate");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitStrobe();
    int n;
    n = 0;
    while (frame_strobe !== 1'b1 && n < 40) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    if (frame_strobe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL strobe wait: no frame_strobe within 40 cycles");
    end
  endtask

  typedef struct {
    logic [79:0] seq;
    int          n;
    bit          expLink;
    int          expErr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int strobes;
    int n;
    logic [7:0] x, y, b;

    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2;

    // Idle after reset: centred, link down, strobe every FT cycles.
    resetDut();
    strobes = 0;
    repeat (48) begin
      applyStimulus(1'b0, 8'h00);
      if (frame_strobe) strobes++;
    end
    expectEq("idle strobe count", strobes, 3);
    expectEq("idle pos_x", int'(pos_x), 128);
    expectEq("idle link", int'(link_ok), 0);

    // Packet X=136 Y=128 and two slew-limited steps.
    resetDut();
    sendPacket(8'h88, 8'h80, 8'h08);
    expectEq("link after commit", int'(link_ok), 1);
    waitStrobe();
    applyStimulus(1'b0, 8'h00);
    expectEq("pos_x first step", int'(pos_x), 132);
    expectEq("pos_y hold", int'(pos_y), 128);
    repeat (FT) applyStimulus(1'b0, 8'h00);
    expectEq("pos_x second step", int'(pos_x), 136);

    // Link loss after three silent frames, then slew back to centre.
    resetDut();
    sendPacket(8'h8C, 8'h74, 8'hF8);
    strobes = 0;
    n = 0;
    while (link_ok && n < 100) begin
      applyStimulus(1'b0, 8'h00);
      if (frame_strobe) strobes++;
      n++;
    end
    expectEq("strobes to link loss", strobes, 4);
    expectEq("link lost", int'(link_ok), 0);
    expectEq("timeout pos_x", int'(pos_x), 140);
    expectEq("timeout pos_y", int'(pos_y), 116);
    repeat (FT) applyStimulus(1'b0, 8'h00);
    expectEq("recentre pos_x", int'(pos_x), 136);
    expectEq("recentre pos_y", int'(pos_y), 120);
    repeat (2 * FT) applyStimulus(1'b0, 8'h00);
    expectEq("centred pos_x", int'(pos_x), 128);
    expectEq("centred pos_y", int'(pos_y), 128);

    // CSUM accepted on the strobe cycle: that strobe still uses old targets.
    resetDut();
    repeat (FT - 4) applyStimulus(1'b0, 8'h00);
    sendPacket(8'hA0, 8'h60, 8'hC0);
    expectEq("coincident pos_x", int'(pos_x), 128);
    expectEq("coincident pos_y", int'(pos_y), 128);
    expectEq("coincident link", int'(link_ok), 1);
    repeat (FT) applyStimulus(1'b0, 8'h00);
    expectEq("after coincident pos_x", int'(pos_x), 132);
    expectEq("after coincident pos_y", int'(pos_y), 124);

    // Reset mid-packet drops the partial packet and all state.
    resetDut();
    sendPacket(8'hA0, 8'h60, 8'hC0);
    repeat (FT - 3) applyStimulus(1'b0, 8'h00);
    expectEq("pre-reset pos_x", int'(pos_x), 132);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h11);
    #3;
    resetDut();
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    expectEq("tail ignored link", int'(link_ok), 0);
    expectEq("tail ignored err", int'(err_count), 0);

    // Packet vectors with hand-derived link/error expectations.
    vecs[0] = '{80'hFF888008000000000000, 4, 1'b1, 0};
    vecs[1] = '{80'hFF102031000000000000, 4, 1'b1, 1};
    vecs[2] = '{80'hFF102030000000000000, 4, 1'b1, 1};
    vecs[3] = '{80'hFF05FF40400000000000, 6, 1'b1, 1};
    vecs[4] = '{80'hFF4040FF010203000000, 7, 1'b1, 1};
    vecs[5] = '{80'hFF010204000000000000, 4, 1'b1, 2};
    vecs[6] = '{80'h1234FFAA55FF00000000, 9, 1'b1, 2};
    resetDut();
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        b = vecs[i].seq[79 - 8 * j -: 8];
        applyStimulus(1'b1, b);
      end
      expectEq($sformatf("vec%0d link", i), int'(link_ok), int'(vecs[i].expLink));
      expectEq($sformatf("vec%0d err", i), int'(err_count), vecs[i].expErr);
    end

    // Error counter saturation.
    resetDut();
    repeat (256) sendPacket(8'h01, 8'h02, 8'h00);
    expectEq("err saturate", int'(err_count), 255);

    // Random traffic against the model.
    resetDut();
    for (int it = 0; it < 300; it++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          sendRand(8'hFF); sendRand(x); sendRand(y); sendRand(x ^ y);
        end
        5: begin
          sendRand(8'hFF); sendRand(x); sendRand(y);
          sendRand((x ^ y) ^ 8'($urandom_range(1, 255)));
        end
        6: sendRand(8'($urandom));
        7: repeat ($urandom_range(40, 70)) applyStimulus(1'b0, 8'h00);
        8: begin
          sendRand(8'hFF); sendRand(x);
        end
        default: repeat ($urandom_range(1, 5)) applyStimulus(1'b0, 8'($urandom));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
